lsu_dmem: RTL and testbench
===========================

# lsu_dmem

Load/store unit and data memory for the single-cycle RV32I core. Sits on the execute/write-back side and consumes the decoder's memory controls (`wr_en`, `bmask`, `ld_sel`) together with the ALU address and rs2 data. Commits stores on the clock edge and returns sign- or zero-extended load data combinationally in the same cycle for the `wb_sel = 01` path. Optionally exposes memory-mapped LED and switch I/O.

## Interface
- `DMEM_DEPTH`, 512, data memory depth in 32-bit words; must be a power of two, so 2 KiB by default.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address from the ALU.
- `st_data`  in  32  store data from rs2; the valid bytes are always right-aligned.
- `wr_en`  in  1  store request.
- `bmask`  in  4  unshifted byte mask: `0001` sb, `0011` sh, `1111` sw.
- `ld_sel`  in  3  load type: `000` lb, `001` lh, `010` lw, `011` lbu, `100` lhu. Other codes behave as lw.
- `ld_data`  out  32  extended load result (combinational).
- `misalign`  out  1  current access is misaligned (combinational).
- `sw_in`  in  32  raw switch inputs; present only with `LSU_IO_EN`.
- `ledr`  out  32  red LED register; present only with `LSU_IO_EN`.
- `ledg`  out  32  green LED register; present only with `LSU_IO_EN`.

## Operation
- **Address map (`addr` bits 31:0):**
  - DMEM at `0x0000_0000` to `DMEM_DEPTH*4-1`.
  - `ledr` at `0x1000_0000` (RW).
  - `ledg` at `0x1000_1000` (RW).
  - switches at `0x1001_0000` (RO).
  - Any other address is unmapped.
- **Word index:** `addr[$clog2(DMEM_DEPTH)+1:2]`. Byte lane = `addr[1:0]`.
- **Store lane mask:** `bmask << addr[1:0]`. Store data is `st_data << (8*addr[1:0])`. Only enabled lanes of the target word change.
- **Misalignment:**
  - Halfword access with `addr[0]=1` is misaligned.
  - Word access with `addr[1:0]≠00` is misaligned.
  - Access width comes from `bmask` when `wr_en=1`, and from `ld_sel` otherwise.
  - A misaligned store writes nothing. A misaligned load returns 0.
- **Load path:**
  - Select the addressed word and shift it right by `8*addr[1:0]`.
  - lb/lh sign-extend from bit 7/15. lbu/lhu zero-extend.
- **Unmapped or write-only cases:**
  - Unmapped load returns 0. Unmapped store is ignored.
  - A store to the switch address is ignored.
- **Switch path:** `sw_in` passes through a 2-flop synchronizer. Loads from the switch address see the second flop.
- **Read-during-write:** a load never overlaps a store in the single-cycle core. If `wr_en=1`, `ld_data` shows the old contents.

## Timing
- Stores commit on the rising `clk` edge where `wr_en=1` and the access is aligned. The new value is readable in the following cycle.
- `ld_data` and `misalign` have zero-cycle latency, combinational from `addr` and `ld_sel` and current state.
- **While `rst_n` is low:**
  - `ledr`, `ledg` and both synchronizer stages are cleared to 0 immediately, without waiting for a clock edge.
  - Stores are blocked.
- **DMEM on reset:** contents are not reset and are preserved across a mid-run reset pulse.
- **Reset release:** the first store can commit on the first rising edge after `rst_n` deasserts.
- **Switch latency:** a change on `sw_in` becomes visible to loads after 2 rising edges.
- **Address wrap:** DMEM address bits above the index and lane bits are decoded. There is no aliasing: `0x0000_0800` is unmapped at the default depth.

## Configuration
- `LSU_IO_EN` defined:
  - Ports `sw_in`, `ledr`, `ledg` exist.
  - The LED registers and the switch synchronizer are built and mapped as above.
- `LSU_IO_EN` undefined:
  - Those ports, registers and the synchronizer are removed.
  - I/O addresses decode as unmapped: loads return 0, stores are ignored.
  - DMEM behaviour is identical in both builds.

## Test plan
- **Store word then byte loads.** sw `0x8055_AA7F` to `0x10`, then lb at `0x10` → `0x0000_007F`. lb at `0x13` → `0xFFFF_FF80`. lbu at `0x13` → `0x0000_0080`.
- **Halfword store.** sh `0x1234_BEEF` to `0x22` over an initial word `0x0000_0000` → word at `0x20` reads `0xBEEF_0000`. lh at `0x22` → `0xFFFF_BEEF`. lhu at `0x22` → `0x0000_BEEF`.
- **Misaligned store.** sw to `0x41` → `misalign=1` and the word at `0x40` is unchanged. lh at `0x43` → `misalign=1`, `ld_data=0`.
- **LED register and reset.** sw `0x0000_00FF` to `0x1000_0000` → `ledr=0xFF` after the edge. Pulse `rst_n` low mid-cycle → `ledr=0` immediately, and DMEM word `0x10` still reads `0x8055_AA7F`.
- **Switch synchronizer.** Set `sw_in=0xA5` → lw at `0x1001_0000` returns 0 after 1 edge and `0xA5` after 2 edges. Then sw to `0x1001_0000` → no state change.
- **Unmapped address.** lw at `0x0000_0800` → `0`. A store there leaves every DMEM word unchanged.
- **I/O compiled out.** Build without `LSU_IO_EN` → lw at `0x1000_0000` returns 0.

Source files
------------

// File: rtl/lsu_dmem_if.sv
// Memory-side bundle between the execute/write-back stage and lsu_dmem.
// master = core datapath, slave = load/store unit.
interface lsu_dmem_if;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        wr_en;
    logic [3:0]  bmask;
    logic [2:0]  ld_sel;
    logic [31:0] ld_data;
    logic        misalign;

    modport master (
        output addr, st_data, wr_en, bmask, ld_sel,
        input  ld_data, misalign
    );

    modport slave (
        input  addr, st_data, wr_en, bmask, ld_sel,
        output ld_data, misalign
    );
endinterface

// File: rtl/lsu_dmem.sv
// Load/store unit + word-organised data memory for the single-cycle RV32I core.
// Define LSU_IO_EN to build the memory-mapped LED registers and switch input.
module lsu_dmem #(
    parameter int DMEM_DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef LSU_IO_EN
    input  logic [31:0] sw_in,
    output logic [31:0] ledr,
    output logic [31:0] ledg,
`endif
    lsu_dmem_if.slave   bus
);
    localparam int AW = $clog2(DMEM_DEPTH);

    logic [31:0]   mem_q [DMEM_DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          dmem_hit;
    logic          is_half;
    logic          is_word;
    logic          mis;
    logic          st_ok;
    logic [3:0]    wmask;
    logic [31:0]   wdata;
    logic [31:0]   rd_word;
    logic [31:0]   sh_word;

    assign idx      = bus.addr[AW+1:2];
    assign lane     = bus.addr[1:0];
    assign dmem_hit = (bus.addr >> (AW + 2)) == 32'd0;

    // Access width follows the store mask on writes, the load type otherwise
    always_comb begin
        is_half = 1'b0;
        is_word = 1'b0;
        if (bus.wr_en) begin
            is_half = bus.bmask == 4'b0011;
            is_word = bus.bmask == 4'b1111;
        end else begin
            case (bus.ld_sel)
                3'b000, 3'b011: ;
                3'b001, 3'b100: is_half = 1'b1;
                default:        is_word = 1'b1;
            endcase
        end
    end

    assign mis          = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    assign bus.misalign = mis;
    assign st_ok        = rst_n & bus.wr_en & ~mis;
    assign wmask        = bus.bmask << lane;
    assign wdata        = bus.st_data << {lane, 3'b000};

    function automatic logic [31:0] merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  m
    );
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Contents survive reset; only the store gate sees rst_n
    always_ff @(posedge clk) begin
        if (st_ok && dmem_hit)
            mem_q[idx] <= merge(mem_q[idx], wdata, wmask);
    end

`ifdef LSU_IO_EN
    localparam logic [29:0] LEDR_W = 30'(32'h1000_0000 >> 2);
    localparam logic [29:0] LEDG_W = 30'(32'h1000_1000 >> 2);
    localparam logic [29:0] SW_W   = 30'(32'h1001_0000 >> 2);

    logic [31:0] ledr_q, ledr_d;
    logic [31:0] ledg_q, ledg_d;
    logic [31:0] sync1_q, sync2_q;
    logic        hit_r, hit_g, hit_s;

    assign hit_r = bus.addr[31:2] == LEDR_W;
    assign hit_g = bus.addr[31:2] == LEDG_W;
    assign hit_s = bus.addr[31:2] == SW_W;

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        if (st_ok && hit_r) ledr_d = merge(ledr_q, wdata, wmask);
        if (st_ok && hit_g) ledg_d = merge(ledg_q, wdata, wmask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr_q  <= '0;
            ledg_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

    assign ledr = ledr_q;
    assign ledg = ledg_q;

    always_comb begin
        rd_word = '0;
        if (dmem_hit)   rd_word = mem_q[idx];
        else if (hit_r) rd_word = ledr_q;
        else if (hit_g) rd_word = ledg_q;
        else if (hit_s) rd_word = sync2_q;
    end
`else
    always_comb begin
        rd_word = '0;
        if (dmem_hit) rd_word = mem_q[idx];
    end
`endif

    assign sh_word = rd_word >> {lane, 3'b000};

    always_comb begin
        bus.ld_data = sh_word;
        case (bus.ld_sel)
            3'b000:  bus.ld_data = {{24{sh_word[7]}}, sh_word[7:0]};
            3'b001:  bus.ld_data = {{16{sh_word[15]}}, sh_word[15:0]};
            3'b011:  bus.ld_data = {24'd0, sh_word[7:0]};
            3'b100:  bus.ld_data = {16'd0, sh_word[15:0]};
            default: bus.ld_data = sh_word;
        endcase
        if (mis) bus.ld_data = '0;
    end
endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: stores, extended loads, misalignment,
// unmapped decode, reset behaviour and (with LSU_IO_EN) LED/switch I/O.
module tb_lsu_dmem;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    lsu_dmem_if bus ();

`ifdef LSU_IO_EN
    logic [31:0] sw_in;
    logic [31:0] ledr;
    logic [31:0] ledg;
`endif

    lsu_dmem #(.DMEM_DEPTH(512)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef LSU_IO_EN
        .sw_in (sw_in),
        .ledr  (ledr),
        .ledg  (ledg),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b011;
    localparam logic [2:0] LHU = 3'b100;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        @(negedge clk);
        bus.addr    = a;
        bus.st_data = d;
        bus.bmask   = m;
        bus.ld_sel  = LW;
        bus.wr_en   = 1'b1;
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] sel);
        bus.wr_en  = 1'b0;
        bus.addr   = a;
        bus.ld_sel = sel;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.addr    = '0;
        bus.st_data = '0;
        bus.wr_en   = 1'b0;
        bus.bmask   = 4'b1111;
        bus.ld_sel  = LW;
`ifdef LSU_IO_EN
        sw_in = '0;
        #1 check("ledr_rst", ledr, 32'h0);
        check("ledg_rst", ledg, 32'h0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // first edge after release must commit
        st(32'h30, 32'h1111_1111, 4'b1111);
        ld(32'h30, LW);
        check("first_st", bus.ld_data, 32'h1111_1111);

        // store attempted under reset is blocked
        @(negedge clk);
        rst_n = 1'b0;
        bus.addr = 32'h30;
        bus.st_data = 32'h2222_2222;
        bus.bmask = 4'b1111;
        bus.ld_sel = LW;
        bus.wr_en = 1'b1;
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ld(32'h30, LW);
        check("rst_blk", bus.ld_data, 32'h1111_1111);

        st(32'h10, 32'h8055_AA7F, 4'b1111);
        ld(32'h10, LW);  check("lw_10", bus.ld_data, 32'h8055_AA7F);
        ld(32'h10, LB);  check("lb_10", bus.ld_data, 32'h0000_007F);
        ld(32'h13, LB);  check("lb_13", bus.ld_data, 32'hFFFF_FF80);
        ld(32'h13, LBU); check("lbu_13", bus.ld_data, 32'h0000_0080);
        ld(32'h12, LH);  check("lh_12", bus.ld_data, 32'hFFFF_8055);
        ld(32'h10, LHU); check("lhu_10", bus.ld_data, 32'h0000_AA7F);
        ld(32'h10, LH);  check("lh_10", bus.ld_data, 32'hFFFF_AA7F);
        ld(32'h11, 3'b111); check("sel_bad", bus.misalign, 32'h1);

        st(32'h20, 32'h0, 4'b1111);
        st(32'h22, 32'h1234_BEEF, 4'b0011);
        ld(32'h20, LW);  check("sh_word", bus.ld_data, 32'hBEEF_0000);
        ld(32'h22, LH);  check("lh_22", bus.ld_data, 32'hFFFF_BEEF);
        ld(32'h22, LHU); check("lhu_22", bus.ld_data, 32'h0000_BEEF);
        st(32'h21, 32'hFFFF_FFC3, 4'b0001);
        ld(32'h20, LW);  check("sb_21", bus.ld_data, 32'hBEEF_C300);

        // misaligned store writes nothing
        st(32'h40, 32'h5566_7788, 4'b1111);
        @(negedge clk);
        bus.addr = 32'h41;
        bus.st_data = 32'hDEAD_BEEF;
        bus.bmask = 4'b1111;
        bus.ld_sel = LB;
        bus.wr_en = 1'b1;
        #1 check("mis_sw", bus.misalign, 32'h1);
        bus.bmask = 4'b0001;
        bus.ld_sel = LW;
        #1 check("mis_sb_mask", bus.misalign, 32'h0);
        bus.bmask = 4'b1111;
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
        ld(32'h40, LW);  check("mis_keep", bus.ld_data, 32'h5566_7788);
        ld(32'h43, LH);  check("mis_lh_f", bus.misalign, 32'h1);
        check("mis_lh_d", bus.ld_data, 32'h0);
        ld(32'h42, LW);  check("mis_lw_d", bus.ld_data, 32'h0);
        ld(32'h42, LHU); check("al_lhu", bus.ld_data, 32'h0000_5566);
        check("al_flag", bus.misalign, 32'h0);

        // read-during-write shows old contents
        @(negedge clk);
        bus.addr = 32'h30;
        bus.st_data = 32'h3333_3333;
        bus.bmask = 4'b1111;
        bus.ld_sel = LW;
        bus.wr_en = 1'b1;
        #1 check("rdw_old", bus.ld_data, 32'h1111_1111);
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
        ld(32'h30, LW);  check("rdw_new", bus.ld_data, 32'h3333_3333);

        // unmapped: no aliasing onto word 0
        st(32'h0, 32'h0BAD_F00D, 4'b1111);
        ld(32'h800, LW); check("unm_ld", bus.ld_data, 32'h0);
        st(32'h800, 32'hFFFF_FFFF, 4'b1111);
        ld(32'h0, LW);   check("unm_w0", bus.ld_data, 32'h0BAD_F00D);
        ld(32'h10, LW);  check("unm_w10", bus.ld_data, 32'h8055_AA7F);
        ld(32'h8000_0010, LW); check("unm_hi", bus.ld_data, 32'h0);

`ifdef LSU_IO_EN
        st(32'h1000_0000, 32'h0000_00FF, 4'b1111);
        check("ledr_wr", ledr, 32'h0000_00FF);
        ld(32'h1000_0000, LW); check("ledr_rd", bus.ld_data, 32'h0000_00FF);
        st(32'h1000_1000, 32'h0000_0A0A, 4'b1111);
        check("ledg_wr", ledg, 32'h0000_0A0A);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("ledr_async", ledr, 32'h0);
        check("ledg_async", ledg, 32'h0);
        #1 rst_n = 1'b1;
        ld(32'h10, LW);  check("mem_keep", bus.ld_data, 32'h8055_AA7F);

        @(negedge clk);
        sw_in = 32'hA5;
        ld(32'h1001_0000, LW);
        @(posedge clk);
        #1 check("sw_1edge", bus.ld_data, 32'h0);
        @(posedge clk);
        #1 check("sw_2edge", bus.ld_data, 32'h0000_00A5);
        st(32'h1001_0000, 32'h0000_0000, 4'b1111);
        ld(32'h1001_0000, LW); check("sw_ro", bus.ld_data, 32'h0000_00A5);
        check("sw_ro_r", ledr, 32'h0);
`else
        ld(32'h1000_0000, LW); check("io_off_r", bus.ld_data, 32'h0);
        st(32'h1000_0000, 32'h0000_00FF, 4'b1111);
        ld(32'h1000_0000, LW); check("io_off_w", bus.ld_data, 32'h0);
        ld(32'h1001_0000, LW); check("io_off_s", bus.ld_data, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        ld(32'h10, LW);  check("mem_keep", bus.ld_data, 32'h8055_AA7F);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
